// File: rtl/conv_mac_array.sv
// Lane-parallel Q8.8 convolution MAC: multiply by a broadcast weight, accumulate a kernel window,
// add bias, optional ReLU, saturate to DW bits. Three register stages: product, accumulate, output.
module conv_mac_array #(
  parameter int unsigned MAC_NUM  = 112,
  parameter int unsigned DW       = 16,
  parameter int unsigned FRAC     = 8,
  parameter int unsigned ACC_W    = 40,
  parameter int unsigned KER_TAPS = 25
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  input  logic                  in_first,
  input  logic                  in_last,
  input  logic                  relu_en,
  input  logic [DW-1:0]         bias,
  input  logic [DW-1:0]         weight,
  input  logic [MAC_NUM*DW-1:0] in_act,
  output logic [MAC_NUM*DW-1:0] out_data,
  output logic                  out_valid,
  output logic                  tap_err,
  output logic                  busy
);

  localparam int unsigned PW = 2 * DW;
  localparam int unsigned RW = ACC_W - FRAC;
  localparam int unsigned CW = 5;
  localparam logic [CW-1:0] CNT_MAX = '1;
  localparam logic signed [RW-1:0] SAT_HI = RW'((2 ** (DW - 1)) - 1);
  localparam logic signed [RW-1:0] SAT_LO = ~SAT_HI;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_OPEN = 1'b1
  } win_state_e;

  win_state_e state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic tap_err_q, tap_err_d;
  logic busy_q, busy_d;

  // Stage 1: products and window markers
  logic signed [PW-1:0]    prod_q [MAC_NUM];
  logic signed [PW-1:0]    prod_d [MAC_NUM];
  logic                    s1_valid_q, s1_valid_d;
  logic                    s1_first_q, s1_first_d;
  logic                    s1_last_q, s1_last_d;
  logic                    s1_relu_q, s1_relu_d;
  logic signed [ACC_W-1:0] s1_bias_q, s1_bias_d;

  // Stage 2: accumulators
  logic signed [ACC_W-1:0] acc_q [MAC_NUM];
  logic signed [ACC_W-1:0] acc_d [MAC_NUM];
  logic                    s2_valid_q, s2_valid_d;
  logic                    s2_last_q, s2_last_d;
  logic                    s2_relu_q, s2_relu_d;

  // Output stage
  logic [MAC_NUM*DW-1:0] out_data_q, out_data_d;
  logic                  out_valid_q, out_valid_d;

  logic signed [PW-1:0] a_ext;
  logic signed [PW-1:0] w_ext;
  logic signed [RW-1:0] res;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    tap_err_d   = tap_err_q;
    s1_valid_d  = in_valid;
    s1_first_d  = s1_first_q;
    s1_last_d   = s1_last_q;
    s1_relu_d   = s1_relu_q;
    s1_bias_d   = s1_bias_q;
    s2_valid_d  = s1_valid_q;
    s2_last_d   = s1_valid_q & s1_last_q;
    s2_relu_d   = s2_relu_q;
    out_valid_d = s2_last_q;
    out_data_d  = out_data_q;
    a_ext       = '0;
    w_ext       = {{DW{weight[DW-1]}}, weight};
    res         = '0;
    for (int i = 0; i < int'(MAC_NUM); i++) begin
      prod_d[i] = prod_q[i];
      acc_d[i]  = acc_q[i];
    end

    // Window tracking: beat count and length / orphan-beat error
    if (in_valid) begin
      if (in_first) begin
        cnt_d = CW'(1);
      end else if (cnt_q != CNT_MAX) begin
        cnt_d = cnt_q + CW'(1);
      end
      if (!in_first && state_q == ST_IDLE) begin
        tap_err_d = 1'b1;
      end
      if (in_last && cnt_d != CW'(KER_TAPS)) begin
        tap_err_d = 1'b1;
      end
      if (in_last) begin
        state_d = ST_IDLE;
      end else if (in_first) begin
        state_d = ST_OPEN;
      end
    end

    if (in_valid) begin
      s1_first_d = in_first;
      s1_last_d  = in_last;
      s1_relu_d  = relu_en;
      if (in_first) begin
        s1_bias_d = {{(ACC_W - DW){bias[DW-1]}}, bias} << FRAC;
      end
      for (int i = 0; i < int'(MAC_NUM); i++) begin
        a_ext     = {{DW{in_act[i*DW + DW - 1]}}, in_act[i*DW +: DW]};
        prod_d[i] = a_ext * w_ext;
      end
    end

    // A first beat restarts from bias; the old sum is read by the output stage on the same edge
    if (s1_valid_q) begin
      for (int i = 0; i < int'(MAC_NUM); i++) begin
        acc_d[i] = (s1_first_q ? s1_bias_q : acc_q[i])
                 + {{(ACC_W - PW){prod_q[i][PW-1]}}, prod_q[i]};
      end
      if (s1_last_q) begin
        s2_relu_d = s1_relu_q;
      end
    end

    if (s2_last_q) begin
      for (int i = 0; i < int'(MAC_NUM); i++) begin
        res = acc_q[i][ACC_W-1:FRAC];
        if (s2_relu_q && res[RW-1]) begin
          out_data_d[i*DW +: DW] = '0;
        end else if (res > SAT_HI) begin
          out_data_d[i*DW +: DW] = SAT_HI[DW-1:0];
        end else if (res < SAT_LO) begin
          out_data_d[i*DW +: DW] = SAT_LO[DW-1:0];
        end else begin
          out_data_d[i*DW +: DW] = res[DW-1:0];
        end
      end
    end

    busy_d = (state_d == ST_OPEN) | s1_valid_d | s2_valid_d | out_valid_d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      tap_err_q   <= 1'b0;
      busy_q      <= 1'b0;
      s1_valid_q  <= 1'b0;
      s1_first_q  <= 1'b0;
      s1_last_q   <= 1'b0;
      s1_relu_q   <= 1'b0;
      s1_bias_q   <= '0;
      s2_valid_q  <= 1'b0;
      s2_last_q   <= 1'b0;
      s2_relu_q   <= 1'b0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      for (int i = 0; i < int'(MAC_NUM); i++) begin
        prod_q[i] <= '0;
        acc_q[i]  <= '0;
      end
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      tap_err_q   <= tap_err_d;
      busy_q      <= busy_d;
      s1_valid_q  <= s1_valid_d;
      s1_first_q  <= s1_first_d;
      s1_last_q   <= s1_last_d;
      s1_relu_q   <= s1_relu_d;
      s1_bias_q   <= s1_bias_d;
      s2_valid_q  <= s2_valid_d;
      s2_last_q   <= s2_last_d;
      s2_relu_q   <= s2_relu_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      for (int i = 0; i < int'(MAC_NUM); i++) begin
        prod_q[i] <= prod_d[i];
        acc_q[i]  <= acc_d[i];
      end
    end
  end

  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;
  assign tap_err   = tap_err_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_conv_mac_array.sv
// Bench for conv_mac_array: constant-table windows, hand-written corner sequences,
// and random windows scored against an integer-arithmetic window model.
module tb_conv_mac_array;

  localparam int unsigned MAC_NUM  = 112;
  localparam int unsigned DW       = 16;
  localparam int unsigned KER_TAPS = 25;
  localparam int unsigned VW       = MAC_NUM * DW;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          in_valid = 1'b0, in_first = 1'b0, in_last = 1'b0, relu_en = 1'b0;
  logic [DW-1:0] bias = '0, weight = '0;
  logic [VW-1:0] in_act = '0;
  logic [VW-1:0] out_data;
  logic          out_valid, tap_err, busy;

  conv_mac_array #(.MAC_NUM(MAC_NUM), .DW(DW), .FRAC(8), .ACC_W(40), .KER_TAPS(KER_TAPS)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_first(in_first), .in_last(in_last),
    .relu_en(relu_en), .bias(bias), .weight(weight), .in_act(in_act),
    .out_data(out_data), .out_valid(out_valid), .tap_err(tap_err), .busy(busy)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { int cyc; logic [VW-1:0] data; } out_ev_t;
  out_ev_t got_q[$];
  out_ev_t exp_q[$];

  always @(negedge clk) begin
    out_ev_t ev;
    if (!rst && out_valid) begin
      ev.cyc = cyc;
      ev.data = out_data;
      got_q.push_back(ev);
    end
  end

  // Reference model: per-lane integer sums over the window
  longint macc[MAC_NUM];
  bit     mopen;
  int     mcnt;
  bit     merr;

  task automatic model_reset();
    for (int i = 0; i < int'(MAC_NUM); i++) macc[i] = 0;
    mopen = 0; mcnt = 0; merr = 0;
    exp_q.delete(); got_q.delete();
  endtask

  task automatic model_beat(input logic first, input logic last, input logic relu,
                            input logic [DW-1:0] b, input logic [DW-1:0] w,
                            input logic [VW-1:0] a, input int edge_cyc);
    out_ev_t e;
    longint p, r;
    if (!first && !mopen) merr = 1;
    mcnt = first ? 1 : (mcnt < 31 ? mcnt + 1 : 31);
    for (int i = 0; i < int'(MAC_NUM); i++) begin
      p = longint'($signed(a[i*DW +: DW])) * longint'($signed(w));
      macc[i] = first ? longint'($signed(b)) * 256 + p : macc[i] + p;
    end
    if (last) begin
      if (mcnt != int'(KER_TAPS)) merr = 1;
      mopen = 0;
      e.cyc = edge_cyc + 2;
      e.data = '0;
      for (int i = 0; i < int'(MAC_NUM); i++) begin
        r = macc[i] >>> 8;
        if (relu && r < 0) r = 0;
        if (r > 32767) r = 32767;
        if (r < -32768) r = -32768;
        e.data[i*DW +: DW] = DW'(r);
      end
      exp_q.push_back(e);
    end else if (first) begin
      mopen = 1;
    end
  endtask

  task automatic check(input string name, input longint got, input longint want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, want);
    end
  endtask

  task automatic check_vec(input string name, input logic [VW-1:0] got, input logic [VW-1:0] want);
    int bad;
    logic [DW-1:0] g, w;
    checks++;
    if (got !== want) begin
      errors++;
      bad = 0;
      for (int i = int'(MAC_NUM) - 1; i >= 0; i--)
        if (got[i*DW +: DW] !== want[i*DW +: DW]) bad = i;
      g = got[bad*DW +: DW];
      w = want[bad*DW +: DW];
      $display("FAIL %s: lane %0d got %h expected %h", name, bad, g, w);
    end
  endtask

  function automatic logic [VW-1:0] splat(input logic [DW-1:0] v);
    return {MAC_NUM{v}};
  endfunction

  function automatic logic [VW-1:0] rand_vec();
    logic [VW-1:0] v;
    for (int i = 0; i < int'(MAC_NUM); i++) v[i*DW +: DW] = DW'($urandom);
    return v;
  endfunction

  task automatic beat(input logic first, input logic last, input logic relu,
                      input logic [DW-1:0] b, input logic [DW-1:0] w, input logic [VW-1:0] a);
    in_valid = 1'b1; in_first = first; in_last = last; relu_en = relu;
    bias = b; weight = w; in_act = a;
    @(posedge clk); #1;
    model_beat(first, last, relu, b, w, a, cyc);
  endtask

  // Idle cycles carry junk on every other input; it must be ignored
  task automatic idle(input int n);
    for (int k = 0; k < n; k++) begin
      in_valid = 1'b0; in_first = 1'($urandom); in_last = 1'($urandom);
      relu_en = 1'($urandom); bias = DW'($urandom); weight = DW'($urandom);
      in_act = rand_vec();
      @(posedge clk); #1;
    end
  endtask

  task automatic run_window(input int taps, input logic [VW-1:0] a, input logic [DW-1:0] w,
                            input logic [DW-1:0] b, input logic relu, input bit gap);
    for (int t = 0; t < taps; t++) begin
      beat(t == 0, t == taps - 1, relu, b, w, a);
      if (gap && t < taps - 1) begin
        idle(1);
        if (t == 12) check("busy in gap", longint'(busy), 1);
      end
    end
  endtask

  task automatic compare_outputs(input string name, input int wait_cycles);
    idle(wait_cycles);
    check({name, " count"}, got_q.size(), exp_q.size());
    for (int k = 0; k < got_q.size() && k < exp_q.size(); k++) begin
      check({name, " cycle"}, got_q[k].cyc, exp_q[k].cyc);
      check_vec({name, " data"}, got_q[k].data, exp_q[k].data);
    end
    got_q.delete();
    exp_q.delete();
  endtask

  typedef struct {
    logic [DW-1:0] act, w, b;
    logic          relu;
    logic [DW-1:0] exp_lane;
  } vec_t;
  vec_t tbl[10];

  logic [VW-1:0] lane_act, lane_exp;
  int c0;

  initial begin
    tbl[0] = '{16'h0100, 16'h0100, 16'h0000, 1'b0, 16'h1900};
    tbl[1] = '{16'h0100, 16'h0100, 16'h0000, 1'b1, 16'h1900};
    tbl[2] = '{16'h7FFF, 16'h7FFF, 16'h0000, 1'b0, 16'h7FFF};
    tbl[3] = '{16'h8000, 16'h7FFF, 16'h0000, 1'b0, 16'h8000};
    tbl[4] = '{16'h8000, 16'h7FFF, 16'h0000, 1'b1, 16'h0000};
    tbl[5] = '{16'h0200, 16'h0100, 16'h0000, 1'b0, 16'h3200};
    tbl[6] = '{16'h0100, 16'h0080, 16'h0100, 1'b0, 16'h0D80};
    tbl[7] = '{16'hFFFF, 16'h0001, 16'h0000, 1'b0, 16'hFFFF};
    tbl[8] = '{16'hFFFF, 16'h0100, 16'h0000, 1'b0, 16'hFFE7};
    tbl[9] = '{16'h0100, 16'h0100, 16'h8000, 1'b0, 16'h9900};

    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check("reset out_valid", longint'(out_valid), 0);
    check("reset tap_err", longint'(tap_err), 0);
    check("reset busy", longint'(busy), 0);
    check_vec("reset out_data", out_data, '0);
    rst = 1'b0;
    idle(2);

    // Uniform 25-tap windows with hand-computed lane values
    for (int n = 0; n < 10; n++) begin
      run_window(int'(KER_TAPS), splat(tbl[n].act), tbl[n].w, tbl[n].b, tbl[n].relu, 1'b0);
      idle(5);
      check($sformatf("tbl%0d pulses", n), got_q.size(), 1);
      if (got_q.size() > 0) check_vec($sformatf("tbl%0d data", n), got_q[0].data, splat(tbl[n].exp_lane));
      check_vec($sformatf("tbl%0d hold", n), out_data, splat(tbl[n].exp_lane));
      check($sformatf("tbl%0d tap_err", n), longint'(tap_err), 0);
      check($sformatf("tbl%0d busy idle", n), longint'(busy), 0);
      compare_outputs($sformatf("tbl%0d model", n), 0);
    end

    // Back-to-back windows with no bubble
    run_window(int'(KER_TAPS), splat(16'h0100), 16'h0100, 16'h0000, 1'b0, 1'b0);
    run_window(int'(KER_TAPS), splat(16'h0200), 16'h0100, 16'h0000, 1'b0, 1'b0);
    idle(5);
    check("b2b pulses", got_q.size(), 2);
    if (got_q.size() == 2) begin
      check("b2b spacing", got_q[1].cyc - got_q[0].cyc, 25);
      check_vec("b2b A", got_q[0].data, splat(16'h1900));
      check_vec("b2b B", got_q[1].data, splat(16'h3200));
    end
    compare_outputs("b2b model", 0);

    // Window with in_valid low every other cycle
    run_window(int'(KER_TAPS), splat(16'h0100), 16'h0100, 16'h0000, 1'b0, 1'b1);
    idle(5);
    check("gap pulses", got_q.size(), 1);
    if (got_q.size() > 0) check_vec("gap data", got_q[0].data, splat(16'h1900));
    compare_outputs("gap model", 0);

    // Random windows, random gaps, relu varying beat to beat
    for (int n = 0; n < 8; n++) begin
      logic [DW-1:0] w, b;
      w = DW'($urandom);
      b = DW'($urandom);
      for (int t = 0; t < int'(KER_TAPS); t++) begin
        beat(t == 0, t == int'(KER_TAPS) - 1, 1'($urandom), b, DW'($urandom_range(0, 1) ? w : DW'($urandom)), rand_vec());
        if ($urandom_range(0, 3) == 0) idle(1);
      end
      compare_outputs($sformatf("rand%0d", n), 5);
      check($sformatf("rand%0d tap_err", n), longint'(tap_err), 0);
    end

    // Lane-distinct 1-tap window
    for (int i = 0; i < int'(MAC_NUM); i++) begin
      lane_act[i*DW +: DW] = DW'(i);
      lane_exp[i*DW +: DW] = DW'(i + 'h80);
    end
    beat(1'b1, 1'b1, 1'b0, 16'h0080, 16'h0100, lane_act);
    idle(5);
    check("lane pulses", got_q.size(), 1);
    if (got_q.size() > 0) check_vec("lane data", got_q[0].data, lane_exp);
    check("lane tap_err", longint'(tap_err), longint'(merr));
    compare_outputs("lane model", 0);

    // Short window flags tap_err but still produces output; reset clears everything
    rst = 1'b1;
    #2;
    rst = 1'b0;
    model_reset();
    idle(2);
    run_window(24, splat(16'h0100), 16'h0100, 16'h0000, 1'b0, 1'b0);
    idle(5);
    check("short pulses", got_q.size(), 1);
    if (got_q.size() > 0) check_vec("short data", got_q[0].data, splat(16'h1800));
    check("short tap_err", longint'(tap_err), 1);
    compare_outputs("short model", 10);
    check("tap_err sticky", longint'(tap_err), 1);

    run_window(10, splat(16'h0100), 16'h0100, 16'h0000, 1'b0, 1'b0);
    check("busy mid window", longint'(busy), 1);
    c0 = got_q.size();
    rst = 1'b1;
    #2;
    check("midrst out_valid", longint'(out_valid), 0);
    check("midrst tap_err", longint'(tap_err), 0);
    check("midrst busy", longint'(busy), 0);
    check_vec("midrst out_data", out_data, '0);
    @(posedge clk); #1;
    rst = 1'b0;
    model_reset();
    idle(6);
    check("midrst no pulse", got_q.size() + c0, 0);
    run_window(int'(KER_TAPS), splat(16'h0100), 16'h0100, 16'h0000, 1'b0, 1'b0);
    idle(5);
    check("post rst pulses", got_q.size(), 1);
    if (got_q.size() > 0) check_vec("post rst data", got_q[0].data, splat(16'h1900));
    check("post rst tap_err", longint'(tap_err), 0);
    compare_outputs("post rst model", 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
